// File: rtl/fpu_mul_pkg.sv
// Shared types and helpers for the FPU multiplier exponent path.
package fpu_mul_pkg;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  // Wide fill patterns; users slice them down to their exponent width.
  localparam int unsigned EXP_W_MAX = 32;
  localparam logic [EXP_W_MAX-1:0] EXP_ONES_MAX = '1;
  localparam logic [EXP_W_MAX-1:0] EXP_ZERO_MAX = '0;

  function automatic int unsigned exp_bias(input int unsigned size_exp);
    return (32'd1 << (size_exp - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/mul_exp_classify.sv
// Per-operand classifier: biased exponent + fraction-nonzero flag -> operand class.
module mul_exp_classify
  import fpu_mul_pkg::*;
#(
  parameter int unsigned SIZE_EXP = 8
) (
  input  logic [SIZE_EXP-1:0] exp_field,
  input  logic                man_nz,
  output fp_class_t           cls
);

  localparam logic [SIZE_EXP-1:0] EXP_ONES = EXP_ONES_MAX[SIZE_EXP-1:0];
  localparam logic [SIZE_EXP-1:0] EXP_ZERO = EXP_ZERO_MAX[SIZE_EXP-1:0];

  // Denormals (zero exponent, nonzero fraction) are flushed to zero.
  always_comb begin
    cls = CLS_NORM;
    if (exp_field == EXP_ZERO) begin
      cls = CLS_ZERO;
    end else if (exp_field == EXP_ONES) begin
      cls = man_nz ? CLS_NAN : CLS_INF;
    end
  end

endmodule

// File: rtl/fpu_mul_exp_pipe.sv
// Pipelined exponent path of the FPU multiplier: biased sum, special-operand
// resolution and overflow/underflow saturation behind a valid/ready handshake.
module fpu_mul_exp_pipe
  import fpu_mul_pkg::*;
#(
  parameter int unsigned SIZE_EXP    = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign_a,
  input  logic                i_sign_b,
  input  logic [SIZE_EXP-1:0] i_exp_a,
  input  logic [SIZE_EXP-1:0] i_exp_b,
  input  logic                i_man_nz_a,
  input  logic                i_man_nz_b,
  input  logic                i_norm_inc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic                o_is_zero,
  output logic                o_is_inf,
  output logic                o_is_nan,
  output logic                o_ovf,
  output logic                o_unf
);

  localparam int unsigned SW = SIZE_EXP + 2;
  localparam logic [SW-1:0] BIAS_W = SW'(exp_bias(SIZE_EXP));
  localparam logic [SW-1:0] OVF_TH = SW'((32'd1 << SIZE_EXP) - 32'd1);
  localparam logic [SIZE_EXP-1:0] EXP_ONES = EXP_ONES_MAX[SIZE_EXP-1:0];
  localparam logic [SIZE_EXP-1:0] EXP_ZERO = EXP_ZERO_MAX[SIZE_EXP-1:0];

  // Stage-1 combinational terms
  fp_class_t      cls_a_c, cls_b_c;
  logic           sign_c;
  logic [SW-1:0]  sum_c;

  mul_exp_classify #(.SIZE_EXP(SIZE_EXP)) u_cls_a (
    .exp_field (i_exp_a),
    .man_nz    (i_man_nz_a),
    .cls       (cls_a_c)
  );

  mul_exp_classify #(.SIZE_EXP(SIZE_EXP)) u_cls_b (
    .exp_field (i_exp_b),
    .man_nz    (i_man_nz_b),
    .cls       (cls_b_c)
  );

  assign sign_c = i_sign_a ^ i_sign_b;
  assign sum_c  = SW'(i_exp_a) + SW'(i_exp_b) + SW'(i_norm_inc);

  // Values presented to the stage-2 resolve logic
  logic           st_valid;
  logic           st_sign;
  logic [SW-1:0]  st_sum;
  fp_class_t      st_cls_a, st_cls_b;
  logic           adv_out;
  logic           adv_in;

  assign adv_out = !o_valid || i_ready;

  // Single-stage build feeds stage-1 terms straight into the output register.
  if (PIPE_STAGES == 1) begin : g_one
    assign st_valid = i_valid;
    assign st_sign  = sign_c;
    assign st_sum   = sum_c;
    assign st_cls_a = cls_a_c;
    assign st_cls_b = cls_b_c;
    assign adv_in   = adv_out;
  end else begin : g_two
    logic          v1;
    logic          sign1;
    logic [SW-1:0] sum1;
    fp_class_t     cls_a1, cls_b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v1     <= 1'b0;
        sign1  <= 1'b0;
        sum1   <= '0;
        cls_a1 <= CLS_NORM;
        cls_b1 <= CLS_NORM;
      end else if (adv_in) begin
        v1 <= i_valid;
        if (i_valid) begin
          sign1  <= sign_c;
          sum1   <= sum_c;
          cls_a1 <= cls_a_c;
          cls_b1 <= cls_b_c;
        end
      end
    end

    assign st_valid = v1;
    assign st_sign  = sign1;
    assign st_sum   = sum1;
    assign st_cls_a = cls_a1;
    assign st_cls_b = cls_b1;
    assign adv_in   = !v1 || adv_out;
  end

  assign o_ready = !i_rst && adv_in;

  // Stage-2 resolve
  logic [SW-1:0]       r;
  logic                nan_any, inf_any, zero_any;
  logic                res_sign;
  logic [SIZE_EXP-1:0] res_exp;
  logic                res_zero, res_inf, res_nan, res_ovf, res_unf;

  always_comb begin
    r        = st_sum - BIAS_W;
    nan_any  = (st_cls_a == CLS_NAN) || (st_cls_b == CLS_NAN);
    inf_any  = (st_cls_a == CLS_INF) || (st_cls_b == CLS_INF);
    zero_any = (st_cls_a == CLS_ZERO) || (st_cls_b == CLS_ZERO);
    res_sign = st_sign;
    res_exp  = EXP_ZERO;
    res_zero = 1'b0;
    res_inf  = 1'b0;
    res_nan  = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (nan_any || (inf_any && zero_any)) begin
      res_nan  = 1'b1;
      res_exp  = EXP_ONES;
      res_sign = 1'b0;
    end else if (inf_any) begin
      res_inf = 1'b1;
      res_exp = EXP_ONES;
    end else if (zero_any) begin
      res_zero = 1'b1;
    end else if (!r[SW-1] && (r >= OVF_TH)) begin
      res_ovf = 1'b1;
      res_inf = 1'b1;
      res_exp = EXP_ONES;
    end else if (r[SW-1] || (r == '0)) begin
      res_unf  = 1'b1;
      res_zero = 1'b1;
    end else begin
      res_exp = r[SIZE_EXP-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_sign    <= 1'b0;
      o_exp     <= '0;
      o_is_zero <= 1'b0;
      o_is_inf  <= 1'b0;
      o_is_nan  <= 1'b0;
      o_ovf     <= 1'b0;
      o_unf     <= 1'b0;
    end else if (adv_out) begin
      o_valid <= st_valid;
      if (st_valid) begin
        o_sign    <= res_sign;
        o_exp     <= res_exp;
        o_is_zero <= res_zero;
        o_is_inf  <= res_inf;
        o_is_nan  <= res_nan;
        o_ovf     <= res_ovf;
        o_unf     <= res_unf;
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_exp_pipe.sv
// Scoreboard bench for fpu_mul_exp_pipe: directed corner vectors, backpressure,
// asynchronous reset and randomized traffic against an integer reference model.
module tb_fpu_mul_exp_pipe;

  localparam int unsigned E = 8;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, o_ready, i_ready;
  logic         i_sign_a, i_sign_b, i_man_nz_a, i_man_nz_b, i_norm_inc;
  logic [E-1:0] i_exp_a, i_exp_b;
  logic         o_valid, o_sign, o_is_zero, o_is_inf, o_is_nan, o_ovf, o_unf;
  logic [E-1:0] o_exp;

  always #5 clk = ~clk;

  fpu_mul_exp_pipe #(.SIZE_EXP(E), .PIPE_STAGES(LAT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sign_a   (i_sign_a),
    .i_sign_b   (i_sign_b),
    .i_exp_a    (i_exp_a),
    .i_exp_b    (i_exp_b),
    .i_man_nz_a (i_man_nz_a),
    .i_man_nz_b (i_man_nz_b),
    .i_norm_inc (i_norm_inc),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sign     (o_sign),
    .o_exp      (o_exp),
    .o_is_zero  (o_is_zero),
    .o_is_inf   (o_is_inf),
    .o_is_nan   (o_is_nan),
    .o_ovf      (o_ovf),
    .o_unf      (o_unf)
  );

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic         zero;
    logic         inf;
    logic         nan;
    logic         ovf;
    logic         unf;
  } res_t;

  res_t exp_q[$];
  res_t act;
  int   checks = 0;
  int   errors = 0;
  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;

  // Reference: IEEE-style rules evaluated on plain integers.
  function automatic res_t model(input logic sa, input logic sb, input int ea, input int eb,
                                 input logic nza, input logic nzb, input logic inc);
    res_t m;
    int   ones;
    int   e;
    bit   za, zb, ia, ib, na, nb;
    m    = '0;
    ones = (1 << E) - 1;
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == ones) && !nza;  ib = (eb == ones) && !nzb;
    na = (ea == ones) && nza;   nb = (eb == ones) && nzb;
    e  = ea + eb + int'(inc) - ((1 << (E - 1)) - 1);
    m.sign = sa ^ sb;
    if (na || nb || ((ia || ib) && (za || zb))) begin
      m.nan = 1'b1; m.exp = '1; m.sign = 1'b0;
    end else if (ia || ib) begin
      m.inf = 1'b1; m.exp = '1;
    end else if (za || zb) begin
      m.zero = 1'b1;
    end else if (e >= ones) begin
      m.ovf = 1'b1; m.inf = 1'b1; m.exp = '1;
    end else if (e <= 0) begin
      m.unf = 1'b1; m.zero = 1'b1;
    end else begin
      m.exp = E'(e);
    end
    return m;
  endfunction

  always begin
    @(negedge clk);
    #1;
    i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor: compares the head of the queue whenever a result is presented,
  // including every stalled cycle, and retires it when it transfers out.
  always begin
    @(negedge clk);
    #3;
    if (!rst && o_valid) begin
      act = {o_sign, o_exp, o_is_zero, o_is_inf, o_is_nan, o_ovf, o_unf};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h required=none", act);
      end else begin
        if (act !== exp_q[0]) begin
          errors++;
          $display("FAIL result got=%h required=%h", act, exp_q[0]);
        end
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic sa, input logic sb, input int ea, input int eb,
                      input logic nza, input logic nzb, input logic inc);
    int n;
    @(negedge clk);
    #1;
    i_sign_a = sa; i_sign_b = sb; i_exp_a = E'(ea); i_exp_b = E'(eb);
    i_man_nz_a = nza; i_man_nz_b = nzb; i_norm_inc = inc; i_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      #1;
      if (o_ready) break;
      @(negedge clk);
      #1;
    end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=o_ready_low required=o_ready_high");
      i_valid = 1'b0;
    end else begin
      exp_q.push_back(model(sa, sb, ea, eb, nza, nzb, inc));
      @(posedge clk);
      #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic check_latency(input string name);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      #3;
      lat++;
      if (o_valid) break;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, lat, LAT);
    end
  endtask

  task automatic drain(input string name);
    int n;
    for (n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s got=%0d_pending required=0", name, exp_q.size());
    end
  endtask

  int d_ea [14] = '{127, 127, 200, 190, 190, 10, 64, 64, 255, 255, 255, 0,   100, 63};
  int d_eb [14] = '{127, 127, 200, 191, 191, 10, 64, 63, 100, 0,   100, 150, 255, 64};
  bit d_inc[14] = '{0,   1,   0,   0,   1,   0,  0,  0,  0,   0,   0,   0,   0,   1};
  bit d_nza[14] = '{0,   0,   0,   0,   0,   0,  0,  0,  1,   0,   0,   0,   0,   0};
  bit d_nzb[14] = '{0,   0,   0,   0,   0,   0,  0,  0,  0,   0,   0,   1,   1,   0};

  function automatic int pick_exp();
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 0) return 0;
    if (k == 1) return (1 << E) - 1;
    if (k == 2) return int'($urandom_range(100, 160));
    return int'($urandom_range(0, (1 << E) - 1));
  endfunction

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_sign_a = 0; i_sign_b = 0; i_exp_a = '0; i_exp_b = '0;
    i_man_nz_a = 0; i_man_nz_b = 0; i_norm_inc = 0;
    #12;
    checks++;
    if ({o_valid, o_sign, o_exp, o_is_zero, o_is_inf, o_is_nan, o_ovf, o_unf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0", {o_valid, o_sign, o_exp, o_is_zero});
    end
    #10 rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b required=1", o_ready);
    end

    // Latency on the first vector, then the remaining directed vectors back-to-back.
    send(1'b0, 1'b1, d_ea[0], d_eb[0], d_nza[0], d_nzb[0], d_inc[0]);
    check_latency("latency");
    for (int i = 1; i < 14; i++)
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d_ea[i], d_eb[i],
           d_nza[i], d_nzb[i], d_inc[i]);
    drain("drain_directed");

    // Backpressure: six back-to-back operands, i_ready low for three cycles.
    fork
      for (int i = 0; i < 6; i++)
        send(1'(i), 1'b0, 100 + i * 7, 90 + i * 3, 1'b0, 1'b0, 1'(i));
      begin
        repeat (3) @(negedge clk);
        rdy_force = 1'b0;
        #2;
        checks++;
        if (o_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_stall got=%b required=0", o_ready);
        end
        repeat (3) @(negedge clk);
        rdy_force = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Asynchronous reset with two results in flight.
    send(1'b1, 1'b0, 130, 131, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 140, 120, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_sign, o_exp, o_is_zero, o_is_inf, o_is_nan, o_ovf, o_unf} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b required=0",
               {o_valid, o_sign, o_exp, o_is_zero, o_is_inf, o_is_nan, o_ovf, o_unf});
    end
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    send(1'b1, 1'b1, 150, 110, 1'b0, 1'b0, 1'b0);
    check_latency("latency_after_reset");
    drain("drain_reset");

    // Randomized traffic with random downstream readiness.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_exp(), pick_exp(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain("drain_random");
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/fpu_mul_exp_pipe.md
Name: fpu_mul_exp_pipe

Overview:
Parametrised, pipelined exponent path for the FPU multiplier. It computes the biased product exponent, e_a + e_b - BIAS + normalisation increment, and classifies special operands (zero / inf / NaN). It also saturates on exponent overflow and underflow, with status flags. The block sits beside the mantissa multiplier and uses a valid/ready handshake, so the FPU_MUL datapath can stall under FFT butterfly backpressure.

Parameters:
SIZE_EXP, 8, exponent width in bits; BIAS = 2^(SIZE_EXP-1)-1 (127 at default)
PIPE_STAGES, 2, register stages; only 1 or 2 legal; 1 merges stage 1 and stage 2 logic into a single register stage

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input operands valid
o_ready  out  1  block can accept operands this cycle
i_sign_a  in  1  sign of operand A
i_sign_b  in  1  sign of operand B
i_exp_a  in  SIZE_EXP  biased exponent of A
i_exp_b  in  SIZE_EXP  biased exponent of B
i_man_nz_a  in  1  mantissa of A non-zero (fraction field)
i_man_nz_b  in  1  mantissa of B non-zero
i_norm_inc  in  1  mantissa product >= 2.0; add 1 to exponent (aligned with operands by the mantissa path)
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_sign  out  1  i_sign_a ^ i_sign_b; forced 0 on NaN
o_exp  out  SIZE_EXP  final biased exponent
o_is_zero  out  1  result is zero
o_is_inf  out  1  result is infinity
o_is_nan  out  1  result is NaN
o_ovf  out  1  overflow saturation occurred (finite inputs)
o_unf  out  1  underflow flush occurred (finite inputs)

Behaviour:
- Reset (i_rst high, asynchronous): all pipeline valid bits cleared; all outputs 0. o_ready is 1 once the block is out of reset. In-flight data is discarded, not flushed.
- Handshake:
  - Transfer in when i_valid & o_ready; transfer out when o_valid & i_ready.
  - Stage k advances when it is empty or stage k+1 advances; last stage advances when !o_valid | i_ready.
  - o_ready = stage-1 advance. A combinational i_ready -> o_ready path is permitted.
  - Full throughput: 1 result/cycle when i_ready stays high.
  - Latency from accept to o_valid: PIPE_STAGES cycles.
  - While stalled (o_valid & !i_ready), all outputs hold stable.
- Stage 1:
  - Register sign XOR and the raw sum s = e_a + e_b + i_norm_inc, width SIZE_EXP+2, unsigned.
  - Register the classification: zero_x = (e_x == 0), with denormals flushed to zero; inf_x = (e_x == all-ones) & !man_nz_x; nan_x = (e_x == all-ones) & man_nz_x.
- Stage 2:
  - r = s - BIAS, evaluated signed in SIZE_EXP+2 bits.
  - Results are selected in priority order:
    1. nan_a | nan_b | (inf_a|inf_b) & (zero_a|zero_b) -> o_is_nan=1, o_exp=all-ones.
    2. inf_a | inf_b -> o_is_inf=1, o_exp=all-ones.
    3. zero_a | zero_b -> o_is_zero=1, o_exp=0.
    4. r >= 2^SIZE_EXP-1 -> o_ovf=1, o_is_inf=1, o_exp=all-ones.
    5. r <= 0 -> o_unf=1, o_is_zero=1, o_exp=0.
    6. Otherwise o_exp = r[SIZE_EXP-1:0].
  - All flags are one-hot except o_ovf/o_unf, which accompany o_is_inf/o_is_zero respectively.
- Boundaries:
  - r == 2^SIZE_EXP-2 is finite (254 at default).
  - r == 1 is finite.
  - i_norm_inc can push r across either threshold; the thresholds are evaluated after the increment.
- Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.

Decomposition:
- Package fpu_mul_pkg:
  - function exp_bias(SIZE_EXP);
  - typedef fp_class_t enum {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN};
  - constants for the all-ones and zero exponent patterns.
- Sub-module mul_exp_classify: combinational per-operand classifier (exp, man_nz -> fp_class_t), instantiated twice in stage 1.
- The top level holds the pipeline registers, the handshake and the stage-2 resolve logic.

Test Plan:
- Finite normal product, i_norm_inc=0: e_a=127, e_b=127 -> o_exp=127, no flags. Repeat with i_norm_inc=1 -> o_exp=128. o_valid asserts exactly 2 cycles after accept.
- Overflow: e_a=200, e_b=200 -> r=273 -> o_exp=255, o_is_inf=1, o_ovf=1. Boundary: e_a=190, e_b=191 -> 254, no flag; e_a=190, e_b=191, i_norm_inc=1 -> 255, overflow.
- Underflow: e_a=10, e_b=10 -> o_exp=0, o_is_zero=1, o_unf=1. Boundary: e_a=64, e_b=64 -> 1, finite; e_a=64, e_b=63 -> 0, underflow.
- Specials: e_a=255, man_nz_a=1 -> NaN. e_a=255, man_nz_a=0 with e_b=0 -> NaN. e_a=255, e_b=100 -> inf, o_sign = sign XOR. e_a=0, e_b=150 -> zero, o_unf=0.
- Backpressure: stream 6 operands back-to-back with i_ready low for 3 cycles mid-stream -> o_ready drops after the pipe fills, outputs hold stable, all 6 results emerge in order, no loss or duplication.
- Reset mid-operation: assert i_rst asynchronously between clock edges with 2 results in flight -> o_valid=0 immediately, all outputs 0. After release, a new operand returns the correct result 2 cycles later.
